// File: rtl/int_ctrl_mod.sv
// -----------------------------------------------------------------------------
// int_ctrl_mod
//   Interrupt controller. Latches peripheral request edges into IF and masks
//   them with IE. When IME is set, it raises a dispatch request at an
//   instruction boundary and hands the 3-bit vector (0..4) to the PC block,
//   which jumps to 0x0040 + 8*vector.
//
// Ports
//   clock          system clock, all state changes on posedge
//   reset          asynchronous active-low reset
//   irq[4:0]       peripheral request levels (VBlank, STAT, Timer, Serial, Joypad)
//   addr_bus       CPU address, decoded for IF/IE access
//   data_bus       CPU write data
//   mem_write      CPU write strobe
//   ei, di, reti   one-cycle pulses from the decoder
//   instr_boundary pulse on the last cycle of every instruction
//   int_ack        control unit accepts the outstanding request
//   int_req        dispatch requested (registered)
//   int_pc_out     latched vector, stable for the whole request
//   reg_rdata      IF/IE read data, combinational from addr_bus
//   reg_hit        addr_bus selects IF or IE
//   ime            interrupt master enable
//   wake           any enabled flag pending, regardless of IME (HALT exit)
// -----------------------------------------------------------------------------
module int_ctrl_mod #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  irq,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_bus,
  input  logic        mem_write,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_boundary,
  input  logic        int_ack,
  output logic        int_req,
  output logic [2:0]  int_pc_out,
  output logic [7:0]  reg_rdata,
  output logic        reg_hit,
  output logic        ime,
  output logic        wake
);

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  state_t     state;
  logic [4:0] if_reg;
  logic [7:0] ie_reg;
  logic [4:0] irq_prev;
  logic       ime_pending;

  logic [4:0] pending;
  logic [2:0] vector;
  logic [4:0] if_next;
  logic       ime_next;
  logic       ime_pending_next;
  logic       if_sel;
  logic       ie_sel;
  logic       ack_take;

  assign if_sel   = (addr_bus == IF_ADDR);
  assign ie_sel   = (addr_bus == IE_ADDR);
  assign reg_hit  = if_sel | ie_sel;
  assign pending  = if_reg & ie_reg[4:0];
  assign wake     = |pending;
  assign ack_take = (state == REQ) && int_ack;

  // Fixed priority: bit 0 (VBlank) wins, so scan high-to-low and let the
  // lowest set bit be the last assignment.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    vector = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) vector = 3'(i);
    end
  end

  always_comb begin
    reg_rdata = 8'hFF;
    if (if_sel)      reg_rdata = {3'b111, if_reg};
    else if (ie_sel) reg_rdata = ie_reg;
  end

  // IF update, lowest precedence first so later lines override:
  // ack clear, then CPU write, then rising-edge set.
  always_comb begin
    if_next = if_reg;
    if (ack_take)             if_next[int_pc_out] = 1'b0;
    if (mem_write && if_sel)  if_next = data_bus[4:0];
    if_next = if_next | (irq & ~irq_prev);
  end

  // IME update. ime_pending is sampled as a register, so an ei pulse cannot
  // be promoted by a boundary in the same cycle; the instruction after EI
  // always completes uninterrupted. di has the final word.
  always_comb begin
    ime_next         = ime;
    ime_pending_next = ime_pending;
    if (instr_boundary && ime_pending) begin
      ime_next         = 1'b1;
      ime_pending_next = 1'b0;
    end
    if (ei)   ime_pending_next = 1'b1;
    if (reti) ime_next         = 1'b1;
    if (ack_take || di) begin
      ime_next         = 1'b0;
      ime_pending_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      if_reg      <= 5'd0;
      ie_reg      <= 8'd0;
      irq_prev    <= 5'd0;
      ime         <= 1'b0;
      ime_pending <= 1'b0;
      int_req     <= 1'b0;
      int_pc_out  <= 3'd0;
    end else begin
      irq_prev    <= irq;
      if_reg      <= if_next;
      ime         <= ime_next;
      ime_pending <= ime_pending_next;
      if (mem_write && ie_sel) ie_reg <= data_bus;

      unique case (state)
        IDLE: begin
          // int_ack here is stale or spurious and is ignored.
          if (instr_boundary && ime && (pending != 5'd0)) begin
            int_pc_out <= vector;
            int_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // Vector is held; no re-arbitration while the request is out.
          if (int_ack || di || (pending == 5'd0)) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl_mod.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl_mod
//   Directed table of per-cycle inputs and hand-computed outputs observed one
//   time unit after the rising edge, followed by a reset-during-request
//   sequence written out by hand.
// -----------------------------------------------------------------------------
module tb_int_ctrl_mod;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;
  localparam logic [15:0] A_X  = 16'hC000;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
  localparam int NVEC = 39;

  logic        clock;
  logic        reset;
  logic [4:0]  irq;
  logic [15:0] addr_bus;
  logic [7:0]  data_bus;
  logic        mem_write, ei, di, reti, instr_boundary, int_ack;
  logic        int_req;
  logic [2:0]  int_pc_out;
  logic [7:0]  reg_rdata;
  logic        reg_hit, ime, wake;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  irq;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr, ei, di, reti, ib, ack;
    logic        e_req;
    logic [2:0]  e_pc;
    logic [7:0]  e_rdata;
    logic        e_ime, e_wake, e_hit;
  } vec_t;

  vec_t tbl [NVEC];

  int_ctrl_mod dut (
    .clock          (clock),
    .reset          (reset),
    .irq            (irq),
    .addr_bus       (addr_bus),
    .data_bus       (data_bus),
    .mem_write      (mem_write),
    .ei             (ei),
    .di             (di),
    .reti           (reti),
    .instr_boundary (instr_boundary),
    .int_ack        (int_ack),
    .int_req        (int_req),
    .int_pc_out     (int_pc_out),
    .reg_rdata      (reg_rdata),
    .reg_hit        (reg_hit),
    .ime            (ime),
    .wake           (wake)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {req,pc,rdata,ime,wake,hit}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] observed();
    return {1'b0, int_req, int_pc_out, reg_rdata, ime, wake, reg_hit};
  endfunction

  function automatic logic [15:0] expect_of(input vec_t v);
    return {1'b0, v.e_req, v.e_pc, v.e_rdata, v.e_ime, v.e_wake, v.e_hit};
  endfunction

  task automatic idle_inputs();
    irq = 5'd0; addr_bus = A_IF; data_bus = 8'd0;
    mem_write = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
    instr_boundary = 1'b0; int_ack = 1'b0;
  endtask

  initial begin
    //         irq       addr  data   wr ei di rt ib ak | req pc    rdata  ime wk hit
    tbl[0]  = '{5'b00000, A_IE, 8'h1F, Y, N, N, N, N, N,   N, 3'd0, 8'h1F, N, N, Y};
    tbl[1]  = '{5'b00000, A_IF, 8'h00, N, N, N, Y, N, N,   N, 3'd0, 8'hE0, Y, N, Y};
    tbl[2]  = '{5'b00101, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hE5, Y, Y, Y};
    tbl[3]  = '{5'b00101, A_IF, 8'h00, N, N, N, N, Y, N,   Y, 3'd0, 8'hE5, Y, Y, Y};
    tbl[4]  = '{5'b00101, A_IF, 8'h00, N, N, N, N, N, N,   Y, 3'd0, 8'hE5, Y, Y, Y};
    tbl[5]  = '{5'b00101, A_IF, 8'h00, N, N, N, N, N, Y,   N, 3'd0, 8'hE4, N, Y, Y};
    tbl[6]  = '{5'b00000, A_IF, 8'h00, Y, N, N, N, N, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[7]  = '{5'b00000, A_IE, 8'h01, Y, N, N, N, N, N,   N, 3'd0, 8'h01, N, N, Y};
    tbl[8]  = '{5'b00001, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hE1, N, Y, Y};
    tbl[9]  = '{5'b00001, A_IF, 8'h00, N, Y, N, N, N, N,   N, 3'd0, 8'hE1, N, Y, Y};
    tbl[10] = '{5'b00001, A_IF, 8'h00, N, N, N, N, Y, N,   N, 3'd0, 8'hE1, Y, Y, Y};
    tbl[11] = '{5'b00001, A_X,  8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hFF, Y, Y, N};
    tbl[12] = '{5'b00001, A_IF, 8'h00, N, N, N, N, Y, N,   Y, 3'd0, 8'hE1, Y, Y, Y};
    tbl[13] = '{5'b00001, A_IF, 8'h00, N, N, N, N, N, Y,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[14] = '{5'b00000, A_IF, 8'h00, N, Y, N, N, Y, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[15] = '{5'b00000, A_IF, 8'h00, N, N, N, N, Y, N,   N, 3'd0, 8'hE0, Y, N, Y};
    tbl[16] = '{5'b00000, A_IF, 8'h00, N, N, Y, N, N, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[17] = '{5'b00000, A_IE, 8'h10, Y, N, N, N, N, N,   N, 3'd0, 8'h10, N, N, Y};
    tbl[18] = '{5'b10000, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hF0, N, Y, Y};
    tbl[19] = '{5'b10000, A_IF, 8'h00, N, N, N, N, Y, N,   N, 3'd0, 8'hF0, N, Y, Y};
    tbl[20] = '{5'b10000, A_IF, 8'h00, Y, N, N, N, N, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[21] = '{5'b10000, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[22] = '{5'b10000, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[23] = '{5'b10000, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hE0, N, N, Y};
    tbl[24] = '{5'b00000, A_IE, 8'h1F, Y, N, N, N, N, N,   N, 3'd0, 8'h1F, N, N, Y};
    tbl[25] = '{5'b00000, A_IF, 8'h00, N, N, N, Y, N, N,   N, 3'd0, 8'hE0, Y, N, Y};
    tbl[26] = '{5'b00010, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd0, 8'hE2, Y, Y, Y};
    tbl[27] = '{5'b00010, A_IF, 8'h00, N, N, N, N, Y, N,   Y, 3'd1, 8'hE2, Y, Y, Y};
    tbl[28] = '{5'b00010, A_IF, 8'h00, Y, N, N, N, N, N,   Y, 3'd1, 8'hE0, Y, N, Y};
    tbl[29] = '{5'b00010, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd1, 8'hE0, Y, N, Y};
    tbl[30] = '{5'b01010, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd1, 8'hE8, Y, Y, Y};
    tbl[31] = '{5'b01010, A_IF, 8'h00, N, N, N, N, Y, N,   Y, 3'd3, 8'hE8, Y, Y, Y};
    tbl[32] = '{5'b01010, A_IF, 8'h00, N, N, Y, N, N, N,   N, 3'd3, 8'hE8, N, Y, Y};
    tbl[33] = '{5'b01010, A_IF, 8'h00, Y, N, N, N, N, N,   N, 3'd3, 8'hE0, N, N, Y};
    tbl[34] = '{5'b00000, A_IF, 8'h00, N, N, N, N, N, N,   N, 3'd3, 8'hE0, N, N, Y};
    tbl[35] = '{5'b01000, A_IF, 8'h00, Y, N, N, N, N, N,   N, 3'd3, 8'hE8, N, Y, Y};
    tbl[36] = '{5'b01000, A_IF, 8'h00, N, N, N, N, N, Y,   N, 3'd3, 8'hE8, N, Y, Y};
    tbl[37] = '{5'b01000, A_IF, 8'h00, N, N, N, Y, N, N,   N, 3'd3, 8'hE8, Y, Y, Y};
    tbl[38] = '{5'b01000, A_IF, 8'h00, N, N, N, N, Y, N,   Y, 3'd3, 8'hE8, Y, Y, Y};

    // Reset state, observed while reset is held.
    idle_inputs();
    reset = 1'b0;
    #2;
    check("reset_if", observed(), {1'b0, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 1'b1});
    addr_bus = A_IE;
    #1;
    check("reset_ie", observed(), {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    addr_bus = A_IF;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      irq            = tbl[i].irq;
      addr_bus       = tbl[i].addr;
      data_bus       = tbl[i].data;
      mem_write      = tbl[i].wr;
      ei             = tbl[i].ei;
      di             = tbl[i].di;
      reti           = tbl[i].reti;
      instr_boundary = tbl[i].ib;
      int_ack        = tbl[i].ack;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), observed(), expect_of(tbl[i]));
    end

    // Asynchronous reset while the request is outstanding: int_req must drop
    // without waiting for a clock edge, and IF/IE/IME must clear.
    @(negedge clock);
    idle_inputs();
    #1;
    reset = 1'b0;
    #1;
    check("rst_midreq_if", observed(), {1'b0, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 1'b1});
    addr_bus = A_IE;
    #1;
    check("rst_midreq_ie", observed(), {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    @(negedge clock);
    reset = 1'b1;
    addr_bus = A_IF;
    @(posedge clock);
    #1;
    check("post_reset", observed(), {1'b0, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
